imem_loader: RTL and testbench

Streams a program image into the instruction RAM that the RV32I pipelined core fetches from, while holding the core in reset. It receives a little-endian byte stream over a valid/ready handshake and parses it as a header, payload words and a checksum. It writes the words to consecutive word addresses. On a good checksum it releases the core; on any error it keeps the core in reset.

---
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian program image (word count, payload
// words, XOR checksum) into the instruction RAM while holding the core in
// reset. The core is released only after a load whose checksum matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [7:0]            in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  core_reset_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // Largest legal word count: the whole RAM.
    localparam logic [DATA_WIDTH:0] DEPTH  = (DATA_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]            state;
    logic [1:0]            byte_cnt;     // byte position within the current 4-byte field
    logic [DATA_WIDTH-9:0] partial;      // first three bytes of the current field
    logic [DATA_WIDTH-1:0] acc;          // running XOR of payload words
    logic [ADDR_WIDTH:0]   n_words;      // payload word count from the header

    logic                  transfer;
    logic                  field_done;
    logic [DATA_WIDTH-1:0] word;

    // Byte acceptance is purely a function of the parsing states.
    assign in_ready_o = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign transfer   = in_valid_i && in_ready_o;
    assign field_done = transfer && (byte_cnt == 2'd3);
    // The 4th byte arrives last and lands in the top bits (little-endian).
    assign word       = {in_data_i, partial};

    // Parser FSM, RAM write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register, including the write strobe, is cleared here so a write
            // scheduled by the edge that coincides with reset is dropped rather than issued.
            state          <= S_IDLE;
            byte_cnt       <= 2'd0;
            partial        <= '0;
            acc            <= '0;
            n_words        <= '0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            core_reset_o   <= 1'b1;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            words_loaded_o <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the strobe defaults low so it
            // is high for exactly the one cycle after a word completes.
            mem_we_o <= 1'b0;

            if (transfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                partial  <= {in_data_i, partial[DATA_WIDTH-9:8]};
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state          <= S_HDR;
                        byte_cnt       <= 2'd0;
                        acc            <= '0;
                        words_loaded_o <= '0;
                        done_o         <= 1'b0;
                        error_o        <= 1'b0;
                        core_reset_o   <= 1'b1;
                    end
                end

                S_HDR: begin
                    if (field_done) begin
                        if ({1'b0, word} > DEPTH) begin
                            state   <= S_ERR;
                            error_o <= 1'b1;
                        end else if (word == '0) begin
                            state <= S_CSUM;
                        end else begin
                            state   <= S_DATA;
                            n_words <= word[ADDR_WIDTH:0];
                        end
                    end
                end

                S_DATA: begin
                    if (field_done) begin
                        mem_we_o       <= 1'b1;
                        mem_addr_o     <= words_loaded_o[ADDR_WIDTH-1:0];
                        mem_wdata_o    <= word;
                        acc            <= acc ^ word;
                        words_loaded_o <= words_loaded_o + WL_ONE;
                        if (words_loaded_o + WL_ONE == n_words) begin
                            state <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (field_done) begin
                        if (word == acc) begin
                            state        <= S_DONE;
                            done_o       <= 1'b1;
                            core_reset_o <= 1'b0;
                        end else begin
                            state   <= S_ERR;
                            error_o <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized image loads against a queue-based reference
// model; a monitor process compares every RAM write with the expected queue.
module tb_imem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_reset;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .in_data_i      (in_data),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .core_reset_o   (core_reset),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img_words[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    function automatic logic [31:0] xor_all();
        logic [31:0] x = 32'h0;
        foreach (img_words[i]) x ^= img_words[i];
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},     64'(in_ready),     64'd0);
        check({tag, "_mem_we"},       64'(mem_we),       64'd0);
        check({tag, "_mem_addr"},     64'(mem_addr),     64'd0);
        check({tag, "_mem_wdata"},    64'(mem_wdata),    64'd0);
        check({tag, "_core_reset"},   64'(core_reset),   64'd1);
        check({tag, "_done"},         64'(done),         64'd0);
        check({tag, "_error"},        64'(error),        64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    // Offer one byte; it must be accepted immediately since the loader is parsing.
    task automatic send_byte(input logic [7:0] b);
        int budget = 0;
        in_data  = b;
        in_valid = 1'b1;
        check("in_ready_while_loading", 64'(in_ready), 64'd1);
        while (in_ready !== 1'b1 && budget < 16) begin
            tick();
            budget++;
        end
        if (in_ready === 1'b1) tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic push_le(inout logic [7:0] q[$], input logic [31:0] w);
        for (int k = 0; k < 4; k++) q.push_back(8'(w >> (8 * k)));
    endtask

    // One complete load of img_words with header count n and checksum csum.
    // gap_mode: 0 none, 1 one idle cycle before every byte, 2 random gaps.
    task automatic run_load(input string tag, input logic [31:0] n, input logic [31:0] csum,
                            input int gap_mode, input int poke_idx);
        logic [7:0] bq[$];
        bit legal = (n <= 32'(DEPTH));
        bit good  = legal && (csum == xor_all());
        push_le(bq, n);
        if (legal) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back({AW'(i), img_words[i]});
                push_le(bq, img_words[i]);
            end
            push_le(bq, csum);
        end

        pulse_start();
        check({tag, "_start_core_reset"}, 64'(core_reset),   64'd1);
        check({tag, "_start_done"},       64'(done),         64'd0);
        check({tag, "_start_error"},      64'(error),        64'd0);
        check({tag, "_start_words"},      64'(words_loaded), 64'd0);

        foreach (bq[i]) begin
            if (gap_mode == 1) tick();
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
            if (i == poke_idx) start_i = 1'b1;
            send_byte(bq[i]);
            start_i = 1'b0;
        end

        check({tag, "_done"},       64'(done),         64'(good));
        check({tag, "_error"},      64'(error),        64'(!good));
        check({tag, "_core_reset"}, 64'(core_reset),   64'(!good));
        check({tag, "_in_ready"},   64'(in_ready),     64'd0);
        check({tag, "_words"},      64'(words_loaded), legal ? 64'(n) : 64'd0);
        repeat (3) tick();
        check({tag, "_writes_seen"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done_held"},   64'(done),         64'(good));
        exp_q.delete();
    endtask

    task automatic set_prog3();
        img_words.delete();
        img_words.push_back(32'h0000_0013);
        img_words.push_back(32'h0010_0093);
        img_words.push_back(32'h0020_8133);
    endtask

    // Reset in the middle of a load; if with_byte, the reset edge also carries
    // the byte that completes the first word, so its pending write must vanish.
    task automatic reset_mid_load(input string tag, input int nbytes, input bit with_byte);
        logic [7:0] bq[$];
        set_prog3();
        push_le(bq, 32'd3);
        foreach (img_words[i]) push_le(bq, img_words[i]);
        pulse_start();
        for (int i = 0; i < nbytes; i++) send_byte(bq[i]);
        if (with_byte) begin
            in_data  = bq[nbytes];
            in_valid = 1'b1;
        end
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_reset_vals(tag);
        tick();
        check({tag, "_no_late_write"}, 64'(mem_we), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        logic [31:0] cs;
        reset    = 1'b1;
        start_i  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        set_prog3();
        run_load("prog3", 32'd3, 32'h0030_81B3, 0, -1);
        run_load("prog3_gaps", 32'd3, 32'h0030_81B3, 1, -1);

        img_words.delete();
        run_load("empty", 32'd0, 32'h0, 0, -1);

        set_prog3();
        run_load("bad_csum", 32'd3, 32'hDEAD_BEEF, 0, -1);

        img_words.delete();
        run_load("too_big", 32'd257, 32'h0, 0, -1);

        img_words.delete();
        img_words.push_back(32'h1234_5678);
        run_load("one_word", 32'd1, 32'h1234_5678, 0, -1);

        img_words.delete();
        for (int i = 0; i < DEPTH; i++) img_words.push_back($urandom);
        run_load("full_ram", 32'(DEPTH), xor_all(), 0, -1);

        for (int r = 0; r < 10; r++) begin
            n = 32'($urandom_range(0, 6));
            img_words.delete();
            for (int i = 0; i < int'(n); i++) img_words.push_back($urandom);
            cs = xor_all();
            if ($urandom_range(0, 2) == 0) cs ^= 32'(1) << $urandom_range(0, 31);
            run_load("random", n, cs, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 4 * (int'(n) + 2) - 1)));
        end

        reset_mid_load("rst_byte6", 6, 1'b0);
        reset_mid_load("rst_pending", 7, 1'b1);
        set_prog3();
        run_load("after_reset", 32'd3, 32'h0030_81B3, 2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
